// File: rtl/collision_pkg.sv
// collision_pkg: default sizes, frame-size constants and request-vector typedefs shared by the collision matrix
package collision_pkg;
  localparam int DEF_N_BUBBLES = 4;
  localparam int DEF_N_ARROWS = 2;
  localparam int DEF_X_FRAME_SIZE = 639;
  localparam int DEF_Y_FRAME_SIZE = 479;
  localparam int DEF_INVULN_FRAMES = 60;
  typedef logic [DEF_N_BUBBLES-1:0] bubble_vec_t;
  typedef logic [DEF_N_ARROWS-1:0] arrow_vec_t;
endpackage

// File: rtl/sticky_edge.sv
// sticky_edge: registered first-hit pulse per frame (in: clk, reset, raw, clear=frame start; out: pulse, sticky)
module sticky_edge (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic clear,
  output logic pulse,
  output logic sticky
);
  logic held;
  assign held = sticky & ~clear;
  always_ff @(posedge clk) begin
    if (reset) begin
      pulse <= 1'b0;
      sticky <= 1'b0;
    end else begin
      pulse <= raw & ~held;
      sticky <= held | raw;
    end
  end
endmodule

// File: rtl/collision_matrix.sv
// collision_matrix: per-frame overlap/border first-hit pulses, frame summary and char immunity (in: pixel, requests, startOfFrame; out: hit pulses, summary, charInvulnerable)
module collision_matrix
  import collision_pkg::*;
#(
  parameter int N_BUBBLES = DEF_N_BUBBLES,
  parameter int N_ARROWS = DEF_N_ARROWS,
  parameter int X_FRAME_SIZE = DEF_X_FRAME_SIZE,
  parameter int Y_FRAME_SIZE = DEF_Y_FRAME_SIZE,
  parameter int INVULN_FRAMES = DEF_INVULN_FRAMES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startOfFrame,
  input  logic [10:0]          pixelX,
  input  logic [10:0]          pixelY,
  input  logic                 charDrawingRequest,
  input  logic [N_ARROWS-1:0]  arrowDrawingRequest,
  input  logic [N_BUBBLES-1:0] bubbleDrawingRequest,
  output logic [N_BUBBLES-1:0] bubbleHitArrow,
  output logic [N_ARROWS-1:0]  arrowHitBubble,
  output logic                 bubbleHitChar,
  output logic [N_BUBBLES-1:0] bubbleHitBorderX,
  output logic [N_BUBBLES-1:0] bubbleHitBorderY,
  output logic                 frameSummaryValid,
  output logic [N_BUBBLES-1:0] frameBubbleHits,
  output logic                 charInvulnerable
);
  localparam int W = 3 * N_BUBBLES + N_ARROWS + 1;
  localparam int CW = INVULN_FRAMES > 0 ? $clog2(INVULN_FRAMES + 1) : 1;
  logic edge_x, edge_y, raw_c, load, unused_sticky;
  logic [W-1:0] raw, pulse, sticky;
  logic [CW-1:0] cnt, cnt_nx;
  assign edge_x = pixelX == 11'd0 || pixelX == 11'(X_FRAME_SIZE);
  assign edge_y = pixelY == 11'd0 || pixelY == 11'(Y_FRAME_SIZE);
  // gating the raw char event keeps immune hits from pulsing; immunity only changes at frame start, where stickies clear anyway
  assign raw_c = charDrawingRequest & |bubbleDrawingRequest & ~charInvulnerable;
  // event bits: [bubble-arrow | arrow-bubble | borderX | borderY | char]
  assign raw = {raw_c,
                bubbleDrawingRequest & {N_BUBBLES{edge_y}},
                bubbleDrawingRequest & {N_BUBBLES{edge_x}},
                arrowDrawingRequest & {N_ARROWS{|bubbleDrawingRequest}},
                bubbleDrawingRequest & {N_BUBBLES{|arrowDrawingRequest}}};
  for (genvar i = 0; i < W; i++) begin : g_edge
    sticky_edge u_edge (
      .clk(clk),
      .reset(reset),
      .raw(raw[i]),
      .clear(startOfFrame),
      .pulse(pulse[i]),
      .sticky(sticky[i])
    );
  end
  assign bubbleHitArrow = pulse[0 +: N_BUBBLES];
  assign arrowHitBubble = pulse[N_BUBBLES +: N_ARROWS];
  assign bubbleHitBorderX = pulse[N_BUBBLES + N_ARROWS +: N_BUBBLES];
  assign bubbleHitBorderY = pulse[2 * N_BUBBLES + N_ARROWS +: N_BUBBLES];
  assign bubbleHitChar = pulse[W-1];
  assign unused_sticky = ^sticky[W-2:N_BUBBLES];
  // load fires on the cycle the char pulse is generated and overrides the frame decrement
  assign load = raw_c & ~(sticky[W-1] & ~startOfFrame);
  assign cnt_nx = load ? CW'(INVULN_FRAMES) : (startOfFrame && cnt != '0) ? cnt - 1'b1 : cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      charInvulnerable <= 1'b0;
      frameSummaryValid <= 1'b0;
      frameBubbleHits <= '0;
    end else begin
      cnt <= cnt_nx;
      charInvulnerable <= cnt_nx != '0;
      frameSummaryValid <= startOfFrame;
      if (startOfFrame) frameBubbleHits <= sticky[N_BUBBLES-1:0];
    end
  end
endmodule

// File: tb/tb_collision_matrix.sv
// tb_collision_matrix: directed plus randomized stimulus checked against a per-frame hit-count reference model
module tb_collision_matrix;
  import collision_pkg::*;
  localparam int NB = DEF_N_BUBBLES;
  localparam int NA = DEF_N_ARROWS;
  localparam int INV = 3;
  logic clk = 1'b0;
  logic reset, startOfFrame, charDrawingRequest;
  logic [10:0] pixelX, pixelY;
  arrow_vec_t arrowDrawingRequest, arrowHitBubble;
  bubble_vec_t bubbleDrawingRequest, bubbleHitArrow, bubbleHitBorderX, bubbleHitBorderY, frameBubbleHits;
  logic bubbleHitChar, frameSummaryValid, charInvulnerable;
  int checks = 0, errors = 0;
  int c_ba[NB], c_bx[NB], c_by[NB], c_ab[NA], c_c, imm;
  bubble_vec_t e_ba, e_bx, e_by, e_fbh;
  arrow_vec_t e_ab;
  logic e_c, e_v, e_inv;
  always #5 clk = ~clk;
  collision_matrix #(
    .N_BUBBLES(NB),
    .N_ARROWS(NA),
    .X_FRAME_SIZE(639),
    .Y_FRAME_SIZE(479),
    .INVULN_FRAMES(INV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .startOfFrame(startOfFrame),
    .pixelX(pixelX),
    .pixelY(pixelY),
    .charDrawingRequest(charDrawingRequest),
    .arrowDrawingRequest(arrowDrawingRequest),
    .bubbleDrawingRequest(bubbleDrawingRequest),
    .bubbleHitArrow(bubbleHitArrow),
    .arrowHitBubble(arrowHitBubble),
    .bubbleHitChar(bubbleHitChar),
    .bubbleHitBorderX(bubbleHitBorderX),
    .bubbleHitBorderY(bubbleHitBorderY),
    .frameSummaryValid(frameSummaryValid),
    .frameBubbleHits(frameBubbleHits),
    .charInvulnerable(charInvulnerable)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic clear_counts();
    for (int i = 0; i < NB; i++) begin
      c_ba[i] = 0;
      c_bx[i] = 0;
      c_by[i] = 0;
    end
    for (int j = 0; j < NA; j++) c_ab[j] = 0;
    c_c = 0;
  endtask
  // one clock: drive at negedge, predict registered outputs, compare 1 time unit after posedge
  task automatic step(input bit rst, input bit sof, input int x, input int y, input bit ch,
                      input bit [NA-1:0] arr, input bit [NB-1:0] bub);
    bit immune, hit;
    @(negedge clk);
    reset = rst;
    startOfFrame = sof;
    pixelX = 11'(x);
    pixelY = 11'(y);
    charDrawingRequest = ch;
    arrowDrawingRequest = arr;
    bubbleDrawingRequest = bub;
    if (rst) begin
      clear_counts();
      imm = 0;
      {e_ba, e_bx, e_by, e_fbh, e_ab, e_c, e_v, e_inv} = '0;
    end else begin
      immune = imm > 0;
      e_v = sof;
      if (sof) begin
        for (int i = 0; i < NB; i++) e_fbh[i] = c_ba[i] > 0;
        clear_counts();
      end
      for (int i = 0; i < NB; i++) begin
        hit = bub[i] && arr != 0;
        e_ba[i] = hit && c_ba[i] == 0;
        c_ba[i] += int'(hit);
        hit = bub[i] && (x == 0 || x == 639);
        e_bx[i] = hit && c_bx[i] == 0;
        c_bx[i] += int'(hit);
        hit = bub[i] && (y == 0 || y == 479);
        e_by[i] = hit && c_by[i] == 0;
        c_by[i] += int'(hit);
      end
      for (int j = 0; j < NA; j++) begin
        hit = arr[j] && bub != 0;
        e_ab[j] = hit && c_ab[j] == 0;
        c_ab[j] += int'(hit);
      end
      hit = ch && bub != 0 && !immune;
      e_c = hit && c_c == 0;
      c_c += int'(hit);
      if (e_c) imm = INV;
      else if (sof && imm > 0) imm--;
      e_inv = imm > 0;
    end
    @(posedge clk);
    #1;
    chk("bubbleHitArrow", 32'(bubbleHitArrow), 32'(e_ba));
    chk("arrowHitBubble", 32'(arrowHitBubble), 32'(e_ab));
    chk("bubbleHitChar", 32'(bubbleHitChar), 32'(e_c));
    chk("bubbleHitBorderX", 32'(bubbleHitBorderX), 32'(e_bx));
    chk("bubbleHitBorderY", 32'(bubbleHitBorderY), 32'(e_by));
    chk("frameSummaryValid", 32'(frameSummaryValid), 32'(e_v));
    chk("frameBubbleHits", 32'(frameBubbleHits), 32'(e_fbh));
    chk("charInvulnerable", 32'(charInvulnerable), 32'(e_inv));
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 100, 100, 0, '0, '0);
  endtask
  initial begin
    int x, y;
    step(1, 0, 0, 0, 0, '0, '0);
    step(0, 1, 100, 100, 0, '0, '0);
    for (int k = 0; k < 5; k++) step(0, 0, 100, 100, 0, 2'b01, 4'b0010);
    idle(2);
    step(0, 1, 100, 100, 0, '0, '0);
    idle(1);
    step(0, 0, 200, 200, 0, 2'b11, 4'b1000);
    step(0, 0, 201, 200, 0, 2'b11, 4'b1000);
    step(0, 1, 100, 100, 0, 2'b01, 4'b0010);
    step(0, 0, 101, 100, 0, 2'b01, 4'b0010);
    idle(1);
    step(0, 1, 100, 100, 0, '0, '0);
    step(0, 0, 300, 300, 1, 2'b01, 4'b0001);
    step(0, 0, 301, 300, 1, '0, 4'b0001);
    for (int f = 0; f < 4; f++) begin
      step(0, 1, 100, 100, 0, '0, '0);
      idle(1);
      step(0, 0, 300, 300, 1, '0, 4'b0100);
      idle(1);
    end
    step(0, 1, 100, 100, 0, '0, '0);
    step(0, 0, 639, 200, 0, '0, 4'b0001);
    step(0, 0, 639, 201, 0, '0, 4'b0001);
    step(0, 0, 300, 0, 0, '0, 4'b0001);
    step(0, 0, 301, 0, 0, '0, 4'b0001);
    step(0, 0, 638, 200, 0, '0, 4'b0010);
    step(0, 0, 100, 100, 0, 2'b10, 4'b0100);
    step(1, 0, 100, 100, 0, 2'b10, 4'b0100);
    step(0, 0, 100, 100, 0, 2'b10, 4'b0100);
    idle(1);
    for (int k = 0; k < 3000; k++) begin
      x = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 3) == 0 ? 639 : $urandom_range(1, 640);
      y = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 3) == 0 ? 479 : $urandom_range(1, 480);
      step($urandom_range(0, 400) == 0, $urandom_range(0, 20) == 0, x, y,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0 ? NA'($urandom) : '0,
           $urandom_range(0, 2) == 0 ? NB'($urandom) : '0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
